led_frame_arbiter: RTL and testbench

Arbitrates ownership of the LED frame RAM write port and the strip-refresh handshake (update_request / update_done) between REQ_NUM frame producers, e.g. colour-effect engines and a CPU-side writer. A granted producer owns the RAM for a whole frame: it writes pixels through the arbiter, which generates the RAM write-clock pulses, then commits. The arbiter then drives the refresh request to the LED driver, waits for completion, acknowledges the producer and releases the grant. Grants are round-robin.

---
 rtl/led_frame_arbiter_if.sv | 31 +++
 rtl/led_frame_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_led_frame_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_arbiter_if.sv
// Producer / RAM / LED-driver signal bundle around led_frame_arbiter.
// master drives requests and driver status; slave is the arbiter.
interface led_frame_arbiter_if #(
  parameter int unsigned ReqNum  = 2,
  parameter int unsigned AddrBit = 5
);
  logic [ReqNum-1:0]         req;
  logic [ReqNum-1:0]         gnt;
  logic [ReqNum-1:0]         wr_en;
  logic [ReqNum*AddrBit-1:0] wr_addr;
  logic [ReqNum*24-1:0]      wr_data;
  logic                      wr_ready;
  logic [ReqNum-1:0]         commit;
  logic [ReqNum-1:0]         ack;
  logic                      ram_wrclock;
  logic [AddrBit-1:0]        ram_wraddress;
  logic [23:0]               ram_data;
  logic                      update_request;
  logic                      update_done;
  logic                      timeout_err;

  modport master (
    output req, wr_en, wr_addr, wr_data, commit, update_done,
    input  gnt, wr_ready, ack, ram_wrclock, ram_wraddress, ram_data, update_request, timeout_err
  );

  modport slave (
    input  req, wr_en, wr_addr, wr_data, commit, update_done,
    output gnt, wr_ready, ack, ram_wrclock, ram_wraddress, ram_data, update_request, timeout_err
  );
endinterface

// File: rtl/led_frame_arbiter.sv
// Round-robin owner of the LED frame RAM write port and the strip refresh handshake.
// A granted producer writes a whole frame, commits, and is acked once the refresh ends.
module led_frame_arbiter #(
  parameter int unsigned ReqNum   = 2,
  parameter int unsigned LedNum   = 16,
  parameter int unsigned AddrBit  = $clog2(LedNum) + 1,
  parameter int unsigned UpdPulse = 11,
  parameter int unsigned Timeout  = 1000000
) (
  input logic                clk_i,
  input logic                rst_ni,
  led_frame_arbiter_if.slave bus_io
);
  localparam int unsigned OwnW   = (ReqNum > 1) ? $clog2(ReqNum) : 1;
  localparam int unsigned CntMax = (Timeout > UpdPulse) ? Timeout : UpdPulse;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StGrant, StWrSetup, StWrHi, StWrLo, StUpdReq, StUpdWait, StRelease
  } state_e;

  state_e              state_q, state_d;
  logic [OwnW-1:0]     owner_q, owner_d;
  logic [OwnW-1:0]     last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                do_ack_q, do_ack_d;
  logic [ReqNum-1:0]   gnt_q, gnt_d;
  logic [ReqNum-1:0]   ack_q, ack_d;
  logic                wrclk_q, wrclk_d;
  logic [AddrBit-1:0]  waddr_q, waddr_d;
  logic [23:0]         wdata_q, wdata_d;
  logic                upd_q, upd_d;
  logic                terr_q, terr_d;

  logic [AddrBit-1:0]  addr_arr [ReqNum];
  logic [23:0]         data_arr [ReqNum];
  logic                own_req, own_wr, own_commit;
  logic [AddrBit-1:0]  own_addr;
  logic [23:0]         own_data;
  logic                pick_valid;
  logic [OwnW-1:0]     pick, cand;

  for (genvar g = 0; g < ReqNum; g++) begin : gen_unpack
    assign addr_arr[g] = bus_io.wr_addr[g*AddrBit +: AddrBit];
    assign data_arr[g] = bus_io.wr_data[g*24 +: 24];
  end

  assign own_req    = bus_io.req[owner_q];
  assign own_wr     = bus_io.wr_en[owner_q];
  assign own_commit = bus_io.commit[owner_q];
  assign own_addr   = addr_arr[owner_q];
  assign own_data   = data_arr[owner_q];

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= ReqNum; i++) begin
      cand = OwnW'((32'(last_q) + i) % ReqNum);
      if (!pick_valid && bus_io.req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    do_ack_d = do_ack_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    wrclk_d  = wrclk_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    upd_d    = upd_q;
    terr_d   = terr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          owner_d      = pick;
          do_ack_d     = 1'b0;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        // A write beats a simultaneous commit; the owner re-asserts commit later.
        if (own_wr) begin
          state_d = StWrSetup;
          if (32'(own_addr) < LedNum) begin
            waddr_d = own_addr;
            wdata_d = own_data;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (own_commit) begin
          cnt_d   = '0;
          upd_d   = 1'b1;
          state_d = StUpdReq;
        end else if (!own_req) begin
          state_d = StRelease;
        end
      end
      StWrSetup: begin
        if (!drop_q) wrclk_d = 1'b1;
        state_d = StWrHi;
      end
      StWrHi: begin
        wrclk_d = 1'b0;
        state_d = StWrLo;
      end
      StWrLo: state_d = StGrant;
      StUpdReq: begin
        if (cnt_q == CntW'(UpdPulse - 1)) begin
          upd_d   = 1'b0;
          cnt_d   = '0;
          state_d = StUpdWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StUpdWait: begin
        if (bus_io.update_done) begin
          do_ack_d = 1'b1;
          state_d  = StRelease;
        end else if (cnt_q == CntW'(Timeout - 1)) begin
          terr_d   = 1'b1;
          do_ack_d = 1'b1;
          state_d  = StRelease;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        gnt_d = '0;
        if (do_ack_q) ack_d[owner_q] = 1'b1;
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= OwnW'(ReqNum - 1);
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      do_ack_q <= 1'b0;
      gnt_q    <= '0;
      ack_q    <= '0;
      wrclk_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      upd_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      do_ack_q <= do_ack_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      wrclk_q  <= wrclk_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      upd_q    <= upd_d;
      terr_q   <= terr_d;
    end
  end

  assign bus_io.gnt            = gnt_q;
  assign bus_io.ack            = ack_q;
  assign bus_io.wr_ready       = (state_q == StGrant);
  assign bus_io.ram_wrclock    = wrclk_q;
  assign bus_io.ram_wraddress  = waddr_q;
  assign bus_io.ram_data       = wdata_q;
  assign bus_io.update_request = upd_q;
  assign bus_io.timeout_err    = terr_q;
endmodule

// File: tb/tb_led_frame_arbiter.sv
// Bench for led_frame_arbiter: random frames checked against a RAM image,
// round-robin order and handshake timing derived from the block's rules.
module tb_led_frame_arbiter;
  localparam int ReqNum     = 2;
  localparam int LedNum     = 16;
  localparam int AddrBit    = 5;
  localparam int UpdPulse   = 11;
  localparam int TimeoutCyc = 100;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rr_last;
  int   wrclk_pulses = 0;
  logic [23:0]        ram_seen  [LedNum];
  logic [23:0]        ram_model [LedNum];
  logic [AddrBit-1:0] last_addr;
  logic [23:0]        last_data;

  led_frame_arbiter_if #(.ReqNum(ReqNum), .AddrBit(AddrBit)) bus ();

  led_frame_arbiter #(
    .ReqNum  (ReqNum),
    .LedNum  (LedNum),
    .AddrBit (AddrBit),
    .UpdPulse(UpdPulse),
    .Timeout (TimeoutCyc)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RAM itself: captures on each rising write clock.
  always @(posedge bus.ram_wrclock) begin
    if (int'(bus.ram_wraddress) < LedNum) ram_seen[int'(bus.ram_wraddress)] = bus.ram_data;
    wrclk_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ReqNum-1:0] onehot(input int i);
    logic [ReqNum-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int next_rr(input logic [ReqNum-1:0] r, input int last);
    for (int i = 1; i <= ReqNum; i++) begin
      if (r[(last + i) % ReqNum]) return (last + i) % ReqNum;
    end
    return -1;
  endfunction

  task automatic wait_gnt(output logic [ReqNum-1:0] g, output bit ok);
    for (int i = 0; i < 20; i++) begin
      if (bus.gnt !== '0) break;
      tick();
    end
    g  = bus.gnt;
    ok = (bus.gnt !== '0);
  endtask

  task automatic do_write(input int idx, input logic [AddrBit-1:0] a, input logic [23:0] d,
                          input bit with_commit, output logic [AddrBit-1:0] o_addr,
                          output logic [23:0] o_data, output logic o_hi, output logic o_lo,
                          output logic o_rdy, output logic o_upd);
    bus.wr_en[idx]                   = 1'b1;
    bus.wr_addr[idx*AddrBit +: AddrBit] = a;
    bus.wr_data[idx*24 +: 24]        = d;
    if (with_commit) bus.commit[idx] = 1'b1;
    tick();
    bus.wr_en  = '0;
    bus.commit = '0;
    o_addr = bus.ram_wraddress;
    o_data = bus.ram_data;
    o_upd  = bus.update_request;
    tick();
    o_hi   = bus.ram_wrclock;
    o_upd  = o_upd | bus.update_request;
    tick();
    o_lo   = bus.ram_wrclock;
    o_upd  = o_upd | bus.update_request;
    tick();
    o_rdy  = bus.wr_ready;
    o_upd  = o_upd | bus.update_request;
  endtask

  // Called right after the commit edge; returns one cycle after the release edge.
  task automatic run_refresh(input int drv_delay, input bit noise, output int upd_cycles,
                             output bit early);
    upd_cycles = 0;
    early      = 1'b0;
    while (bus.update_request === 1'b1 && upd_cycles < 4 * UpdPulse) begin
      upd_cycles++;
      bus.update_done = noise && (upd_cycles < UpdPulse);
      tick();
      if (bus.ack !== '0 || bus.gnt === '0) early = 1'b1;
    end
    bus.update_done = 1'b0;
    for (int i = 0; i < drv_delay; i++) begin
      tick();
      if (bus.ack !== '0 || bus.gnt === '0 || bus.update_request !== 1'b0) early = 1'b1;
    end
    bus.update_done = 1'b1;
    tick();
    bus.update_done = 1'b0;
    if (bus.ack !== '0 || bus.gnt === '0) early = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.wr_en = '0; bus.commit = '0; bus.update_done = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) tick();
    n_tests++;
    if ({bus.gnt, bus.ack, bus.wr_ready, bus.ram_wrclock, bus.ram_wraddress, bus.ram_data,
         bus.update_request, bus.timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b ack=%b rdy=%b wrclk=%b addr=%h data=%h upd=%b terr=%b, want all 0",
               bus.gnt, bus.ack, bus.wr_ready, bus.ram_wrclock, bus.ram_wraddress,
               bus.ram_data, bus.update_request, bus.timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = ReqNum - 1;
    last_addr = '0;
    last_data = '0;
    tick();
    n_tests++;
    if (bus.gnt !== '0 || bus.wr_ready !== 1'b0 || bus.update_request !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: gnt=%b rdy=%b upd=%b, want 0/0/0",
               bus.gnt, bus.wr_ready, bus.update_request);
    end
  endtask

  task automatic test_single_frame();
    logic [AddrBit-1:0] oa; logic [23:0] od; logic oh, ol, orr, ou;
    int p0, upd_cycles, bad; bit early;
    bus.req = 2'b01;
    tick();
    n_tests++;
    if (bus.gnt !== 2'b01 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_grant_latency: gnt=%b rdy=%b, want 01/1", bus.gnt, bus.wr_ready);
    end
    p0 = wrclk_pulses;
    for (int i = 0; i < LedNum; i++) begin
      do_write(0, AddrBit'(i), 24'h0000FF + 24'(i), 1'b0, oa, od, oh, ol, orr, ou);
      ram_model[i] = 24'h0000FF + 24'(i);
      last_addr = AddrBit'(i);
      last_data = 24'h0000FF + 24'(i);
      n_tests++;
      if ({oa, od, oh, ol, orr, ou} !== {AddrBit'(i), 24'h0000FF + 24'(i), 4'b1010}) begin
        n_fail++;
        $display("FAIL frame_pixel_%0d: addr=%h data=%h hi=%b lo=%b rdy=%b upd=%b, want %h %h 1 0 1 0",
                 i, oa, od, oh, ol, orr, ou, i, 24'h0000FF + 24'(i));
      end
    end
    bad = 0;
    for (int i = 0; i < LedNum; i++) if (ram_seen[i] !== ram_model[i]) bad++;
    n_tests++;
    if (wrclk_pulses - p0 != LedNum || bad != 0) begin
      n_fail++;
      $display("FAIL frame_ram_image: pulses=%0d bad_words=%0d, want %0d pulses 0 bad",
               wrclk_pulses - p0, bad, LedNum);
    end
    bus.commit[0] = 1'b1;
    tick();
    bus.commit = '0;
    bus.req    = '0;
    run_refresh(50, 1'b0, upd_cycles, early);
    n_tests++;
    if (upd_cycles != UpdPulse || early || bus.ack !== 2'b01 || bus.gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL frame_refresh: upd_cycles=%0d early=%0b ack=%b gnt=%b, want %0d 0 01 00",
               upd_cycles, early, bus.ack, bus.gnt, UpdPulse);
    end
    rr_last = 0;
    tick();
    n_tests++;
    if (bus.ack !== 2'b00 || bus.gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL frame_ack_width: ack=%b gnt=%b, want 00 00", bus.ack, bus.gnt);
    end
  endtask

  task automatic test_contention();
    logic [ReqNum-1:0] g; bit ok, early;
    logic [AddrBit-1:0] oa; logic [23:0] od; logic oh, ol, orr, ou;
    logic [AddrBit-1:0] a; logic [23:0] d;
    int ex, oth, nw, upd_cycles, bad;
    bus.req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      ex  = next_rr(2'b11, rr_last);
      oth = (ex + 1) % ReqNum;
      wait_gnt(g, ok);
      n_tests++;
      if (!ok || g !== onehot(ex)) begin
        n_fail++;
        $display("FAIL contention_grant_%0d: gnt=%b, want %b", f, g, onehot(ex));
      end
      bus.commit[oth] = 1'b1;
      tick();
      bus.commit = '0;
      n_tests++;
      if (bus.update_request !== 1'b0 || bus.wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL nonowner_commit_%0d: upd=%b rdy=%b, want 0 1", f, bus.update_request,
                 bus.wr_ready);
      end
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        a = AddrBit'($urandom_range(0, LedNum - 1));
        d = 24'($urandom);
        do_write(ex, a, d, 1'b0, oa, od, oh, ol, orr, ou);
        ram_model[int'(a)] = d;
        last_addr = a;
        last_data = d;
        n_tests++;
        if ({oa, od, oh, ol, orr, ou} !== {a, d, 4'b1010}) begin
          n_fail++;
          $display("FAIL contention_write_%0d_%0d: addr=%h data=%h hi=%b lo=%b rdy=%b upd=%b, want %h %h 1 0 1 0",
                   f, k, oa, od, oh, ol, orr, ou, a, d);
        end
      end
      bus.commit[ex] = 1'b1;
      tick();
      bus.commit = '0;
      run_refresh($urandom_range(0, 20), f[0], upd_cycles, early);
      n_tests++;
      if (upd_cycles != UpdPulse || early || bus.ack !== onehot(ex) || bus.gnt !== '0) begin
        n_fail++;
        $display("FAIL contention_release_%0d: upd_cycles=%0d early=%0b ack=%b gnt=%b, want %0d 0 %b 00",
                 f, upd_cycles, early, bus.ack, bus.gnt, UpdPulse, onehot(ex));
      end
      rr_last = ex;
      tick();
      n_tests++;
      if (bus.ack !== '0 || bus.gnt !== onehot(next_rr(2'b11, rr_last))) begin
        n_fail++;
        $display("FAIL contention_regrant_%0d: ack=%b gnt=%b, want 00 %b", f, bus.ack, bus.gnt,
                 onehot(next_rr(2'b11, rr_last)));
      end
    end
    rr_last = next_rr(2'b11, rr_last);
    bus.req = '0;
    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < LedNum; i++) if (ram_seen[i] !== ram_model[i]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL contention_ram_image: bad_words=%0d, want 0", bad);
    end
  endtask

  task automatic test_abort_bad_addr();
    logic [ReqNum-1:0] g; bit ok, seen;
    logic [AddrBit-1:0] oa; logic [23:0] od; logic oh, ol, orr, ou;
    logic [AddrBit-1:0] bad_a;
    int p0;
    bus.req = 2'b10;
    wait_gnt(g, ok);
    n_tests++;
    if (!ok || g !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_grant: gnt=%b, want 10", g);
    end
    for (int k = 0; k < 2; k++) begin
      bad_a = (k == 0) ? AddrBit'(LedNum) : AddrBit'($urandom_range(LedNum, 2**AddrBit - 1));
      p0 = wrclk_pulses;
      do_write(1, bad_a, 24'($urandom), 1'b0, oa, od, oh, ol, orr, ou);
      n_tests++;
      if ({oa, od, oh, ol, orr, ou} !== {last_addr, last_data, 4'b0010} || wrclk_pulses != p0)
      begin
        n_fail++;
        $display("FAIL bad_addr_%0d: addr=%h data=%h hi=%b lo=%b rdy=%b upd=%b pulses=%0d, want %h %h 0 0 1 0 0",
                 k, oa, od, oh, ol, orr, ou, wrclk_pulses - p0, last_addr, last_data);
      end
    end
    bus.req = '0;
    seen = 1'b0;
    tick();
    if (bus.ack !== '0 || bus.update_request !== 1'b0) seen = 1'b1;
    tick();
    n_tests++;
    if (bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL abort_release: gnt=%b, want 00", bus.gnt);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.ack !== '0 || bus.update_request !== 1'b0) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_ack: ack or update_request seen=1, want 0");
    end
    rr_last = 1;
  endtask

  task automatic test_simultaneous();
    logic [ReqNum-1:0] g; bit ok, early;
    logic [AddrBit-1:0] oa; logic [23:0] od; logic oh, ol, orr, ou;
    logic [AddrBit-1:0] a; logic [23:0] d;
    int ex, upd_cycles;
    bus.req = 2'b11;
    ex = next_rr(2'b11, rr_last);
    wait_gnt(g, ok);
    n_tests++;
    if (!ok || g !== onehot(ex)) begin
      n_fail++;
      $display("FAIL simul_grant: gnt=%b, want %b", g, onehot(ex));
    end
    a = AddrBit'($urandom_range(0, LedNum - 1));
    d = 24'($urandom);
    do_write(ex, a, d, 1'b1, oa, od, oh, ol, orr, ou);
    ram_model[int'(a)] = d;
    last_addr = a;
    last_data = d;
    tick();
    n_tests++;
    if ({oa, od, oh, ol, orr, ou, bus.update_request, ram_seen[int'(a)]} !== {a, d, 5'b10100, d})
    begin
      n_fail++;
      $display("FAIL simul_write_wins: addr=%h data=%h hi=%b lo=%b rdy=%b upd=%b,%b ram=%h, want %h %h 1 0 1 0,0 %h",
               oa, od, oh, ol, orr, ou, bus.update_request, ram_seen[int'(a)], a, d, d);
    end
    bus.commit[ex] = 1'b1;
    tick();
    bus.commit = '0;
    bus.req    = '0;
    n_tests++;
    if (bus.update_request !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_later_commit: upd=%b, want 1", bus.update_request);
    end
    run_refresh(3, 1'b0, upd_cycles, early);
    n_tests++;
    if (upd_cycles != UpdPulse || early || bus.ack !== onehot(ex) || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL simul_release: upd_cycles=%0d early=%0b ack=%b gnt=%b, want %0d 0 %b 00",
               upd_cycles, early, bus.ack, bus.gnt, UpdPulse, onehot(ex));
    end
    rr_last = ex;
    tick();
  endtask

  task automatic test_timeout();
    logic [ReqNum-1:0] g; bit ok;
    int ex, nx, upd_cycles, k;
    bus.req = 2'b11;
    ex = next_rr(2'b11, rr_last);
    wait_gnt(g, ok);
    n_tests++;
    if (!ok || g !== onehot(ex)) begin
      n_fail++;
      $display("FAIL timeout_grant: gnt=%b, want %b", g, onehot(ex));
    end
    bus.commit[ex] = 1'b1;
    tick();
    bus.commit = '0;
    upd_cycles = 0;
    while (bus.update_request === 1'b1 && upd_cycles < 4 * UpdPulse) begin
      upd_cycles++;
      tick();
    end
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 3 * TimeoutCyc) begin
      tick();
      k++;
    end
    n_tests++;
    if (upd_cycles != UpdPulse || k != TimeoutCyc || bus.gnt !== onehot(ex) || bus.ack !== '0)
    begin
      n_fail++;
      $display("FAIL timeout_detect: upd_cycles=%0d wait=%0d gnt=%b ack=%b, want %0d %0d %b 00",
               upd_cycles, k, bus.gnt, bus.ack, UpdPulse, TimeoutCyc, onehot(ex));
    end
    tick();
    n_tests++;
    if (bus.ack !== onehot(ex) || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL timeout_ack: ack=%b gnt=%b, want %b 00", bus.ack, bus.gnt, onehot(ex));
    end
    rr_last = ex;
    nx = next_rr(2'b11, rr_last);
    tick();
    n_tests++;
    if (bus.gnt !== onehot(nx) || bus.ack !== '0 || bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next_owner: gnt=%b ack=%b terr=%b, want %b 00 1",
               bus.gnt, bus.ack, bus.timeout_err, onehot(nx));
    end
    bus.req = '0;
    repeat (3) tick();
    rr_last = nx;
  endtask

  task automatic test_reset_mid_refresh();
    logic [ReqNum-1:0] g; bit ok;
    int ex;
    bus.req = 2'b11;
    ex = next_rr(2'b11, rr_last);
    wait_gnt(g, ok);
    bus.commit[ex] = 1'b1;
    tick();
    bus.commit = '0;
    repeat (3) tick();
    n_tests++;
    if (bus.update_request !== 1'b1 || bus.gnt !== onehot(ex)) begin
      n_fail++;
      $display("FAIL midreset_setup: upd=%b gnt=%b, want 1 %b", bus.update_request, bus.gnt,
               onehot(ex));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.gnt, bus.ack, bus.wr_ready, bus.ram_wrclock, bus.ram_wraddress, bus.ram_data,
         bus.update_request, bus.timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: gnt=%b ack=%b rdy=%b wrclk=%b addr=%h data=%h upd=%b terr=%b, want all 0",
               bus.gnt, bus.ack, bus.wr_ready, bus.ram_wrclock, bus.ram_wraddress,
               bus.ram_data, bus.update_request, bus.timeout_err);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = ReqNum - 1;
    tick();
    n_tests++;
    if (bus.gnt !== onehot(next_rr(2'b11, rr_last))) begin
      n_fail++;
      $display("FAIL midreset_first_grant: gnt=%b, want %b", bus.gnt,
               onehot(next_rr(2'b11, rr_last)));
    end
    bus.req = '0;
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < LedNum; i++) begin
      ram_seen[i]  = '0;
      ram_model[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_contention();
    test_abort_bad_addr();
    test_simultaneous();
    test_timeout();
    test_reset_mid_refresh();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
